// File: rtl/cv32e40px_x_offload_tracker.sv
// Tracks offloaded CORE-V-XIF instructions in a DEPTH-entry table with out-of-order results,
// per-register pending-write counters, a commit/kill phase and ID-reuse protection.
module cv32e40px_x_offload_tracker #(
  parameter int ID_WIDTH      = 4,
  parameter int DEPTH         = 4,
  parameter int RF_READ_PORTS = 3,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            instr_valid_i,
  input  logic [RF_READ_PORTS-1:0][4:0]   rs_addr_i,
  input  logic [RF_READ_PORTS-1:0]        rs_used_i,
  input  logic [4:0]                      rd_addr_i,
  input  logic                            id_ready_i,
  input  logic                            kill_i,
  input  logic                            data_req_dec_i,
  input  logic                            illegal_reset_i,
  output logic                            x_issue_valid_o,
  input  logic                            x_issue_ready_i,
  input  logic                            x_issue_resp_accept_i,
  input  logic                            x_issue_resp_writeback_i,
  input  logic                            x_issue_resp_loadstore_i,
  output logic [ID_WIDTH-1:0]             x_issue_id_o,
  output logic                            x_commit_valid_o,
  output logic [ID_WIDTH-1:0]             x_commit_id_o,
  output logic                            x_commit_kill_o,
  input  logic                            x_result_valid_i,
  output logic                            x_result_ready_o,
  input  logic [ID_WIDTH-1:0]             x_result_id_i,
  input  logic                            x_result_we_i,
  input  logic                            x_mem_done_i,
  output logic                            x_stall_o,
  output logic                            x_illegal_insn_o,
  output logic                            protocol_err_o
);

  logic [DEPTH-1:0]    live_q, cmt_q, wb_q, ls_q;
  logic [ID_WIDTH-1:0] id_q [DEPTH];
  logic [4:0]          rd_q [DEPTH];
  logic [CNT_W-1:0]    pend_q [32];
  logic [CNT_W-1:0]    pend_d [32];
  logic [ID_WIDTH-1:0] next_id_q;
  logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;
  logic                offloaded_q, illegal_q, perr_q;

  logic [DEPTH-1:0]    free_oh, res_oh, uc_oh;
  logic                free_found, full, id_busy, dep;
  logic                res_hit, res_wb, res_frees;
  logic [4:0]          res_rd;
  logic                uc_hit, uc_wb, uc_ls;
  logic [4:0]          uc_rd;
  logic [ID_WIDTH-1:0] uc_id;
  logic                issue_hs, alloc, kill_entry, commit_entry;
  logic                mem_inc, mem_kill;
  logic [CNT_W:0]      mem_sum, mem_sub;

  // Table lookups: lowest free slot, result match, and the single uncommitted entry.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    id_busy    = 1'b0;
    res_oh     = '0;
    res_rd     = '0;
    res_wb     = 1'b0;
    uc_oh      = '0;
    uc_rd      = '0;
    uc_wb      = 1'b0;
    uc_ls      = 1'b0;
    uc_id      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!live_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
      if (live_q[i] && id_q[i] == next_id_q) id_busy = 1'b1;
      if (x_result_valid_i && live_q[i] && cmt_q[i] && id_q[i] == x_result_id_i) begin
        res_oh[i] = 1'b1;
        res_rd    = rd_q[i];
        res_wb    = wb_q[i];
      end
      if (live_q[i] && !cmt_q[i]) begin
        uc_oh[i] = 1'b1;
        uc_rd    = rd_q[i];
        uc_wb    = wb_q[i];
        uc_ls    = ls_q[i];
        uc_id    = id_q[i];
      end
    end
  end

  assign full      = &live_q;
  assign res_hit   = |res_oh;
  assign uc_hit    = |uc_oh;
  assign res_frees = res_hit & res_wb & x_result_we_i & (res_rd != 5'd0);

  // A last pending write retiring this cycle already satisfies the consumer.
  always_comb begin
    dep = 1'b0;
    for (int p = 0; p < RF_READ_PORTS; p++) begin
      if (rs_used_i[p] && rs_addr_i[p] != 5'd0 && pend_q[rs_addr_i[p]] != '0 &&
          !(pend_q[rs_addr_i[p]] == CNT_W'(1) && res_frees && res_rd == rs_addr_i[p]))
        dep = 1'b1;
    end
  end

  assign x_issue_valid_o  = instr_valid_i & ~offloaded_q & ~dep & ~full & ~id_busy & ~kill_i;
  assign x_issue_id_o     = next_id_q;
  assign issue_hs         = x_issue_valid_o & x_issue_ready_i;
  assign alloc            = issue_hs & x_issue_resp_accept_i;
  assign kill_entry       = uc_hit & kill_i;
  assign commit_entry     = uc_hit & id_ready_i & ~kill_i;
  assign x_result_ready_o = 1'b1;
  assign x_illegal_insn_o = illegal_q;
  assign protocol_err_o   = perr_q;

  assign x_stall_o = dep | full | id_busy | (x_issue_valid_o & ~x_issue_ready_i) |
                     (data_req_dec_i & (mem_cnt_q != '0));

  // An instruction issued while ID advances commits in its issue cycle.
  always_comb begin
    x_commit_valid_o = 1'b0;
    x_commit_kill_o  = 1'b0;
    x_commit_id_o    = '0;
    if (uc_hit && (id_ready_i || kill_i)) begin
      x_commit_valid_o = 1'b1;
      x_commit_kill_o  = kill_i;
      x_commit_id_o    = uc_id;
    end else if (alloc && id_ready_i) begin
      x_commit_valid_o = 1'b1;
      x_commit_id_o    = next_id_q;
    end
  end

  always_comb begin
    pend_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      pend_d[r] = pend_q[r]
                + CNT_W'(alloc & x_issue_resp_writeback_i & (rd_addr_i == 5'(r)))
                - CNT_W'(kill_entry & uc_wb & (uc_rd == 5'(r)))
                - CNT_W'(res_frees & (res_rd == 5'(r)));
    end
  end

  // A killed load/store never reaches memory, so its count is withdrawn.
  assign mem_inc   = alloc & x_issue_resp_loadstore_i;
  assign mem_kill  = kill_entry & uc_ls;
  assign mem_sum   = {1'b0, mem_cnt_q} + (CNT_W+1)'(mem_inc);
  assign mem_sub   = (CNT_W+1)'(x_mem_done_i) + (CNT_W+1)'(mem_kill);
  assign mem_cnt_d = (mem_sum > mem_sub) ? CNT_W'(mem_sum - mem_sub) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q      <= '0;
      cmt_q       <= '0;
      wb_q        <= '0;
      ls_q        <= '0;
      next_id_q   <= '0;
      mem_cnt_q   <= '0;
      offloaded_q <= 1'b0;
      illegal_q   <= 1'b0;
      perr_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
        rd_q[i] <= '0;
      end
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (res_oh[i] || (kill_entry && uc_oh[i])) live_q[i] <= 1'b0;
        if (commit_entry && uc_oh[i]) cmt_q[i] <= 1'b1;
        if (alloc && free_oh[i]) begin
          live_q[i] <= 1'b1;
          cmt_q[i]  <= id_ready_i;
          id_q[i]   <= next_id_q;
          rd_q[i]   <= rd_addr_i;
          wb_q[i]   <= x_issue_resp_writeback_i;
          ls_q[i]   <= x_issue_resp_loadstore_i;
        end
      end
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
      next_id_q <= next_id_q + ID_WIDTH'(alloc);
      mem_cnt_q <= mem_cnt_d;
      if (id_ready_i || kill_i) offloaded_q <= 1'b0;
      else if (alloc)           offloaded_q <= 1'b1;
      if (illegal_reset_i)                          illegal_q <= 1'b0;
      else if (issue_hs && !x_issue_resp_accept_i)  illegal_q <= 1'b1;
      perr_q <= x_result_valid_i & ~res_hit;
    end
  end

endmodule

// File: tb/tb_cv32e40px_x_offload_tracker.sv
// Directed bench: a 4-bit-ID tracker for most scenarios plus a 2-bit-ID instance for ID wrap.
module tb_cv32e40px_x_offload_tracker;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [2:0][4:0] rs_addr;
  logic [2:0]      rs_used;
  logic [4:0]      rd_addr;
  logic            id_ready, kill, data_req_dec, illegal_reset;
  logic            issue_ready, resp_accept, resp_wb, resp_ls;
  logic            result_valid, result_we, mem_done;
  logic [3:0]      result_id;

  logic       issue_valid, commit_valid, commit_kill, result_ready, stall, illegal, perr;
  logic [3:0] issue_id, commit_id;
  logic       b_issue_valid, b_commit_valid, b_commit_kill, b_result_ready, b_stall, b_illegal, b_perr;
  logic [1:0] b_issue_id, b_commit_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cv32e40px_x_offload_tracker #(.ID_WIDTH(4), .DEPTH(4), .RF_READ_PORTS(3)) dut (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .rs_addr_i(rs_addr),
    .rs_used_i(rs_used), .rd_addr_i(rd_addr), .id_ready_i(id_ready), .kill_i(kill),
    .data_req_dec_i(data_req_dec), .illegal_reset_i(illegal_reset),
    .x_issue_valid_o(issue_valid), .x_issue_ready_i(issue_ready),
    .x_issue_resp_accept_i(resp_accept), .x_issue_resp_writeback_i(resp_wb),
    .x_issue_resp_loadstore_i(resp_ls), .x_issue_id_o(issue_id),
    .x_commit_valid_o(commit_valid), .x_commit_id_o(commit_id), .x_commit_kill_o(commit_kill),
    .x_result_valid_i(result_valid), .x_result_ready_o(result_ready),
    .x_result_id_i(result_id), .x_result_we_i(result_we), .x_mem_done_i(mem_done),
    .x_stall_o(stall), .x_illegal_insn_o(illegal), .protocol_err_o(perr)
  );

  cv32e40px_x_offload_tracker #(.ID_WIDTH(2), .DEPTH(4), .RF_READ_PORTS(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .rs_addr_i(rs_addr),
    .rs_used_i(rs_used), .rd_addr_i(rd_addr), .id_ready_i(id_ready), .kill_i(kill),
    .data_req_dec_i(data_req_dec), .illegal_reset_i(illegal_reset),
    .x_issue_valid_o(b_issue_valid), .x_issue_ready_i(issue_ready),
    .x_issue_resp_accept_i(resp_accept), .x_issue_resp_writeback_i(resp_wb),
    .x_issue_resp_loadstore_i(resp_ls), .x_issue_id_o(b_issue_id),
    .x_commit_valid_o(b_commit_valid), .x_commit_id_o(b_commit_id), .x_commit_kill_o(b_commit_kill),
    .x_result_valid_i(result_valid), .x_result_ready_o(b_result_ready),
    .x_result_id_i(result_id[1:0]), .x_result_we_i(result_we), .x_mem_done_i(mem_done),
    .x_stall_o(b_stall), .x_illegal_insn_o(b_illegal), .protocol_err_o(b_perr)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 0; rs_addr = '0; rs_used = '0; rd_addr = '0; id_ready = 0; kill = 0;
    data_req_dec = 0; illegal_reset = 0; issue_ready = 1; resp_accept = 1; resp_wb = 0;
    resp_ls = 0; result_valid = 0; result_we = 0; result_id = '0; mem_done = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic wb, input logic ls,
                           input logic acc, input logic rdy);
    instr_valid = 1; rd_addr = rd; resp_wb = wb; resp_ls = ls; resp_accept = acc; id_ready = rdy;
  endtask

  task automatic set_result(input logic [3:0] id);
    result_valid = 1; result_id = id; result_we = 1;
  endtask

  initial begin
    rst = 1;
    do_reset();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_id", issue_id, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_id", commit_id, 0);
    chk("rst_result_ready", result_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_perr", perr, 0);

    // Fill the table: ids 0..3 to rd 5..8, each committed in its issue cycle.
    for (int k = 0; k < 4; k++) begin
      set_issue(5'(5 + k), 1, 0, 1, 1);
      #1;
      chk("fill_issue_valid", issue_valid, 1);
      chk("fill_issue_id", issue_id, k);
      chk("fill_commit_valid", commit_valid, 1);
      chk("fill_commit_id", commit_id, k);
      chk("fill_commit_kill", commit_kill, 0);
      tick();
    end
    set_issue(5'd9, 1, 0, 1, 1);
    #1;
    chk("full_stall", stall, 1);
    chk("full_issue_valid", issue_valid, 0);
    set_result(4'd2);
    #1;
    chk("full_same_cycle_result", issue_valid, 0);
    tick();
    result_valid = 0;
    #1;
    chk("refill_issue_valid", issue_valid, 1);
    chk("refill_issue_id", issue_id, 4);
    chk("refill_stall", stall, 0);
    chk("good_result_no_perr", perr, 0);
    tick();
    idle();
    foreach (result_id[i]) ;
    set_result(4'd0); tick();
    set_result(4'd1); tick();
    set_result(4'd3); tick();
    set_result(4'd4); tick();
    idle();
    #1;
    chk("drained_stall", stall, 0);

    // Two writers of x10 (ids 5, 6); a reader stalls until the second result.
    set_issue(5'd10, 1, 0, 1, 1);
    #1;
    chk("raw_a_id", issue_id, 5);
    tick();
    #1;
    chk("raw_b_valid", issue_valid, 1);
    chk("raw_b_id", issue_id, 6);
    tick();
    idle();
    rs_addr[0] = 5'd10; rs_used[0] = 1;
    #1;
    chk("raw_cnt2_stall", stall, 1);
    set_result(4'd5);
    #1;
    chk("raw_cnt2_result_stall", stall, 1);
    tick();
    result_valid = 0;
    #1;
    chk("raw_cnt1_stall", stall, 1);
    set_result(4'd6);
    #1;
    chk("raw_cnt1_bypass_stall", stall, 0);
    tick();
    result_valid = 0;
    #1;
    chk("raw_cnt0_stall", stall, 0);
    idle();

    // Issue id 7 without advancing ID, then kill it.
    set_issue(5'd12, 1, 0, 1, 0);
    #1;
    chk("kill_issue_id", issue_id, 7);
    chk("kill_issue_nocommit", commit_valid, 0);
    tick();
    #1;
    chk("offloaded_blocks_reissue", issue_valid, 0);
    rs_addr[1] = 5'd12; rs_used[1] = 1;
    #1;
    chk("kill_dep_stall", stall, 1);
    kill = 1;
    #1;
    chk("kill_commit_valid", commit_valid, 1);
    chk("kill_commit_kill", commit_kill, 1);
    chk("kill_commit_id", commit_id, 7);
    tick();
    kill = 0; instr_valid = 0;
    #1;
    chk("kill_dep_cleared", stall, 0);
    chk("kill_no_commit_after", commit_valid, 0);
    idle();

    // 2-bit IDs: ids 0..3 live, results 1 then 0; id 0 reuse waits for its result.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_issue(5'(1 + k), 1, 0, 1, 1);
      #1;
      chk("wrap_fill_id", b_issue_id, k);
      tick();
    end
    set_issue(5'd5, 1, 0, 1, 1);
    set_result(4'd1);
    #1;
    chk("wrap_full_stall", b_stall, 1);
    tick();
    result_valid = 0;
    #1;
    chk("wrap_busy_valid", b_issue_valid, 0);
    chk("wrap_busy_stall", b_stall, 1);
    set_result(4'd0);
    #1;
    chk("wrap_busy_same_cycle", b_issue_valid, 0);
    tick();
    result_valid = 0;
    #1;
    chk("wrap_reuse_valid", b_issue_valid, 1);
    chk("wrap_reuse_id", b_issue_id, 0);
    chk("wrap_reuse_stall", b_stall, 0);
    idle();

    // Rejected offload raises the illegal flag until acknowledged.
    do_reset();
    set_issue(5'd3, 1, 0, 0, 0);
    #1;
    chk("illegal_issue_valid", issue_valid, 1);
    chk("illegal_not_yet", illegal, 0);
    tick();
    instr_valid = 0;
    #1;
    chk("illegal_set", illegal, 1);
    tick();
    chk("illegal_held", illegal, 1);
    illegal_reset = 1;
    tick();
    chk("illegal_cleared", illegal, 0);
    set_issue(5'd3, 1, 0, 0, 0);
    illegal_reset = 1;
    tick();
    chk("illegal_reset_wins", illegal, 0);
    chk("illegal_no_alloc_id", issue_id, 0);
    idle();
    set_result(4'd7);
    #1;
    chk("perr_registered", perr, 0);
    tick();
    result_valid = 0;
    chk("perr_pulse", perr, 1);
    tick();
    chk("perr_single", perr, 0);

    // Load/store accounting against core memory accesses.
    set_issue(5'd0, 0, 1, 1, 1);
    #1;
    chk("ls_issue_id", issue_id, 0);
    tick();
    idle();
    data_req_dec = 1;
    #1;
    chk("ls_load_stall", stall, 1);
    tick();
    chk("ls_load_stall_held", stall, 1);
    mem_done = 1;
    #1;
    chk("ls_done_cycle_stall", stall, 1);
    tick();
    mem_done = 0;
    #1;
    chk("ls_released", stall, 0);
    data_req_dec = 0;
    set_issue(5'd0, 0, 1, 1, 1);
    tick();
    set_issue(5'd0, 0, 1, 1, 1);
    mem_done = 1;
    #1;
    chk("ls_both_issue_id", issue_id, 2);
    tick();
    idle();
    data_req_dec = 1;
    #1;
    chk("ls_cnt_unchanged_stall", stall, 1);
    mem_done = 1;
    tick();
    mem_done = 0;
    #1;
    chk("ls_final_release", stall, 0);
    idle();

    // Reset with entries in flight: a late result is now a protocol error.
    do_reset();
    set_result(4'd1);
    tick();
    result_valid = 0;
    chk("late_result_perr", perr, 1);
    chk("late_reset_id", issue_id, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
